// File: rtl/pixel_filter.sv
// -----------------------------------------------------------------------------
// pixel_filter
//   Streaming RGB444 stage between the camera CDC FIFO read side and the
//   frame-buffer write path. Pixels are popped from the FIFO, passed through a
//   3-stage pipeline (S0 read issue, S1 capture, S2 compute/tag/buffer write)
//   and delivered from a small credit-managed output buffer.
//
//   Operations (latched per frame at x=0,y=0): 0 pass, 1 gray,
//   2 binary threshold against the live i_thresh, 3 invert.
//
//   Optional build macro PIXEL_FILTER_TESTPATTERN_EN adds i_pattern: while it
//   is sampled high at frame start, an 8-bar colour generator replaces the
//   FIFO as the pixel source.
//
// Ports
//   i_sysclk      system clock
//   db_rstn       asynchronous active-low reset
//   i_mode        operation select, sampled at frame start
//   i_thresh      threshold for mode 2 (used live)
//   o_rd          FIFO read enable; i_rdata is valid the following cycle
//   i_rdata       FIFO read data
//   i_rempty      FIFO empty flag
//   o_valid       output pixel valid
//   o_data        output pixel {R,G,B}
//   o_sof         pixel is x=0,y=0 (qualified by o_valid)
//   o_eol         pixel is x=ROWLENGTH-1 (qualified by o_valid)
//   i_ready       downstream ready
//   o_frame_done  one-cycle pulse after the last pixel of a frame is accepted
//   i_pattern     (PIXEL_FILTER_TESTPATTERN_EN only) test-pattern select
//
// Handshake: a pixel transfers on every rising edge where o_valid && i_ready.
// While o_valid is high and i_ready is low, o_data/o_sof/o_eol hold steady;
// o_valid never drops without a transfer.
// -----------------------------------------------------------------------------
module pixel_filter #(
  parameter int ROWLENGTH  = 640,
  parameter int ROWS       = 480,
  parameter int DATA_WIDTH = 12,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                  i_sysclk,
  input  logic                  db_rstn,
  input  logic [1:0]            i_mode,
  input  logic [3:0]            i_thresh,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_rempty,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sof,
  output logic                  o_eol,
  input  logic                  i_ready,
  output logic                  o_frame_done
`ifdef PIXEL_FILTER_TESTPATTERN_EN
  ,
  input  logic                  i_pattern
`endif
);

  localparam int XW = (ROWLENGTH > 1) ? $clog2(ROWLENGTH) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int EW = DATA_WIDTH + 2;  // {sof, eol, data}

  // Enable goes high one clock after reset release so o_rd is low in reset.
  logic                  r_en;
  logic                  r_s0_v;       // read issued last cycle; source data valid now
  logic                  r_s1_v;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [1:0]            r_mode;

  logic [EW-1:0]         r_mem [OBUF_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_count;
  logic [YW-1:0]         r_oy;         // line counter on the output side
  logic                  r_frame_done;

  logic                  w_issue;
  logic                  w_credit;
  logic [PW+1:0]         w_used;
  logic [DATA_WIDTH-1:0] w_src;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sof;
  logic                  w_eol;
  logic [1:0]            w_mode_eff;
  logic [3:0]            w_r;
  logic [3:0]            w_g;
  logic [3:0]            w_b;
  logic [7:0]            w_sum;
  logic [3:0]            w_gray;
  logic [DATA_WIDTH-1:0] w_result;
  logic [EW-1:0]         w_head;

  // Credit: buffered entries plus pixels still in S1/S2 must leave room for
  // one more. A same-cycle pop is deliberately not credited.
  assign w_used   = {1'b0, r_count} + (PW+2)'(r_s0_v) + (PW+2)'(r_s1_v);
  assign w_credit = r_en && (w_used < (PW+2)'(OBUF_DEPTH));

`ifdef PIXEL_FILTER_TESTPATTERN_EN
  localparam int BAR_W = ROWLENGTH / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  // Issue-side position, tracked separately so the source choice is made
  // at the frame start of the pixel being requested.
  logic [XW-1:0]         r_ix;
  logic [YW-1:0]         r_iy;
  logic                  r_pat;
  logic [BW-1:0]         r_bx;
  logic [2:0]            r_bar;
  logic                  r_s0_gen;
  logic [DATA_WIDTH-1:0] r_s0_pix;
  logic                  w_at_start;
  logic                  w_pat_now;
  logic [DATA_WIDTH-1:0] w_bar_colour;

  assign w_at_start = (r_ix == '0) && (r_iy == '0);
  assign w_pat_now  = w_at_start ? i_pattern : r_pat;
  assign w_issue    = w_credit && (w_pat_now || !i_rempty);
  assign o_rd       = w_issue && !w_pat_now;
  assign w_src      = r_s0_gen ? r_s0_pix : i_rdata;

  always_comb begin
    w_bar_colour = '0;
    case (r_bar)
      3'd0:    w_bar_colour = 12'hFFF;
      3'd1:    w_bar_colour = 12'hFF0;
      3'd2:    w_bar_colour = 12'h0FF;
      3'd3:    w_bar_colour = 12'h0F0;
      3'd4:    w_bar_colour = 12'hF0F;
      3'd5:    w_bar_colour = 12'hF00;
      3'd6:    w_bar_colour = 12'h00F;
      default: w_bar_colour = 12'h000;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      r_ix     <= '0;
      r_iy     <= '0;
      r_pat    <= 1'b0;
      r_bx     <= '0;
      r_bar    <= '0;
      r_s0_gen <= 1'b0;
      r_s0_pix <= '0;
    end else if (w_issue) begin
      if (w_at_start) r_pat <= i_pattern;
      r_s0_gen <= w_pat_now;
      r_s0_pix <= w_bar_colour;
      if (r_ix == XW'(ROWLENGTH - 1)) begin
        r_ix  <= '0;
        r_bx  <= '0;
        r_bar <= '0;
        r_iy  <= (r_iy == YW'(ROWS - 1)) ? '0 : r_iy + 1'b1;
      end else begin
        r_ix <= r_ix + 1'b1;
        if (r_bx == BW'(BAR_W - 1)) begin
          r_bx  <= '0;
          r_bar <= r_bar + 1'b1;
        end else begin
          r_bx <= r_bx + 1'b1;
        end
      end
    end
  end
`else
  assign w_issue = w_credit && !i_rempty;
  assign o_rd    = w_issue;
  assign w_src   = i_rdata;
`endif

  // S2 compute.
  assign w_sof      = (r_x == '0) && (r_y == '0);
  assign w_eol      = (r_x == XW'(ROWLENGTH - 1));
  // The frame's first pixel already uses the newly sampled mode.
  assign w_mode_eff = w_sof ? i_mode : r_mode;
  assign w_r        = r_s1_data[11:8];
  assign w_g        = r_s1_data[7:4];
  assign w_b        = r_s1_data[3:0];
  assign w_sum      = 8'd5 * {4'd0, w_r} + 8'd9 * {4'd0, w_g} + 8'd2 * {4'd0, w_b};
  assign w_gray     = w_sum[7:4];

  always_comb begin
    w_result = r_s1_data;
    case (w_mode_eff)
      2'd0:    w_result = r_s1_data;
      2'd1:    w_result = {w_gray, w_gray, w_gray};
      2'd2:    w_result = (w_gray >= i_thresh) ? {DATA_WIDTH{1'b1}} : '0;
      default: w_result = {DATA_WIDTH{1'b1}} - r_s1_data;
    endcase
  end

  assign w_push = r_s1_v;
  assign w_pop  = o_valid && i_ready;

  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      r_en      <= 1'b0;
      r_s0_v    <= 1'b0;
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_mode    <= 2'd0;
    end else begin
      r_en   <= 1'b1;
      r_s0_v <= w_issue;
      r_s1_v <= r_s0_v;
      if (r_s0_v) r_s1_data <= w_src;
      if (r_s1_v) begin
        if (w_sof) r_mode <= i_mode;
        if (w_eol) begin
          r_x <= '0;
          r_y <= (r_y == YW'(ROWS - 1)) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  // Output buffer. Credit keeps pushes from ever reaching a full buffer
  // unless a pop happens in the same cycle.
  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      for (int i = 0; i < OBUF_DEPTH; i++) r_mem[i] <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_oy         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_sof, w_eol, w_result};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_frame_done <= w_pop && w_head[EW-2] && (r_oy == YW'(ROWS - 1));
      if (w_pop && w_head[EW-2]) r_oy <= (r_oy == YW'(ROWS - 1)) ? '0 : r_oy + 1'b1;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign o_valid      = (r_count != '0);
  assign o_sof        = w_head[EW-1];
  assign o_eol        = w_head[EW-2];
  assign o_data       = w_head[DATA_WIDTH-1:0];
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/pixel_filter.md
Name: pixel_filter

Overview:
- Streaming RGB444 pixel-processing stage in the i_sysclk domain, between the read side of the front camera CDC FIFO and the BRAM frame-buffer write path.
- Pops pixels from the FIFO and applies a per-frame selectable operation: passthrough, grayscale, binary threshold or invert.
- Tags each pixel with frame/line position.
- Delivers pixels on a valid/ready interface through an internal credit-managed output buffer.

Parameters:
- ROWLENGTH, 640, pixels per line.
- ROWS, 480, lines per frame.
- DATA_WIDTH, 12, pixel width: RGB444 as {R[11:8], G[7:4], B[3:0]}.
- OBUF_DEPTH, 4, output buffer entries (power of 2, ≥4).

Ports:
- i_sysclk  in  1  system clock, 125 MHz.
- db_rstn  in  1  reset, asynchronous, active-low.
- i_mode  in  2  operation: 0 pass, 1 gray, 2 threshold, 3 invert.
- i_thresh  in  4  threshold level for mode 2.
- o_rd  out  1  FIFO read enable.
- i_rdata  in  12  FIFO read data; valid the cycle after o_rd.
- i_rempty  in  1  FIFO empty flag.
- o_valid  out  1  output pixel valid.
- o_data  out  12  output pixel.
- o_sof  out  1  pixel is x=0, y=0; qualified by o_valid.
- o_eol  out  1  pixel is x=ROWLENGTH-1; qualified by o_valid.
- i_ready  in  1  downstream accepts when high with o_valid.
- o_frame_done  out  1  1-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset: clock is i_sysclk; reset is db_rstn, asynchronous, active-low. Reset clears all of the following:
  - o_rd=0, o_valid=0, o_data=0, o_sof=0, o_eol=0, o_frame_done=0;
  - x=0, y=0, active mode=0 (pass);
  - buffer empty; in-flight count=0.
  Deassertion mid-frame restarts at x=0, y=0. Pixels already in the FIFO are treated as a new frame.
- Pipeline, 3 stages:
  - S0: o_rd issue.
  - S1: capture i_rdata.
  - S2: compute, tag and write to the output buffer.
  - Latency from o_rd to buffer write is 2 cycles. The earliest o_valid is 3 cycles after o_rd into an empty block.
- Credit rule:
  - o_rd = !i_rempty && (buffer occupancy + in-flight) < OBUF_DEPTH.
  - In-flight means S1/S2 pixels not yet written to the buffer.
  - The output buffer never overflows; no pixel is dropped.
- Throughput: sustains 1 pixel/cycle when the FIFO is non-empty and i_ready=1.
- Compute (S2), with R, G, B as 4-bit fields:
  - gray = (5R + 9G + 2B) >> 4, an 8-bit sum truncated to 4 bits. All 15s gives 15.
  - Mode 0: output = input.
  - Mode 1: output = {gray, gray, gray}.
  - Mode 2: output = 12'hFFF if gray ≥ i_thresh, else 12'h000.
  - Mode 3: output = 12'hFFF − input.
- Mode latching:
  - i_mode is sampled into the active mode only when a pixel with x=0, y=0 enters S2.
  - A mid-frame change takes effect at the next frame.
  - i_thresh is used live.
- Counters advance per pixel entering S2:
  - x wraps from ROWLENGTH-1 to 0 and increments y.
  - y wraps from ROWS-1 to 0.
  - sof and eol are stored alongside the data in the buffer (14-bit entries).
- Output handshake:
  - o_data, o_sof and o_eol are held stable while o_valid && !i_ready.
  - The buffer pops on o_valid && i_ready.
  - Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- o_frame_done is asserted the cycle after acceptance of the pixel tagged x=ROWLENGTH-1, y=ROWS-1.
- When i_rempty is high, o_rd is low. Already-buffered pixels continue to drain.

Optional Feature:
- Macro: PIXEL_FILTER_TESTPATTERN_EN.
- When defined:
  - Adds input port i_pattern (1 bit).
  - While i_pattern=1, o_rd is held 0 and S1 takes a generated pixel instead of i_rdata. The generator issues one pixel per cycle under the same credit rule.
  - The pattern is 8 vertical bars, each ROWLENGTH/8 wide, in this colour order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - i_pattern is sampled only at frame start, x=0, y=0.
  - The filter mode still applies to pattern pixels.
- When not defined: the port is absent and pixels come only from the FIFO.

Test Plan:
- Reset, then FIFO preloaded with 3 pixels (ABC, 123, FFF), mode 0, i_ready=1 → o_rd high for 3 cycles; o_data ABC, 123, FFF on consecutive cycles; first o_valid 3 cycles after the first o_rd; o_sof only on ABC.
- Mode 1 with pixel F00 → gray=(75)>>4=4, output 444. Mode 1 with 0F0 → 8, output 888.
- Mode 2, i_thresh=8, pixels 0F0 and F00 → FFF then 000. Mode 3 with pixel 1A5 → E5A.
- i_ready=0 with the FIFO non-empty → exactly OBUF_DEPTH pixels are read in total, after which o_rd stays 0 and o_data stays stable. Release i_ready → all pixels appear in order with no loss or duplication.
- Stream of ROWLENGTH*ROWS pixels with the mode changed to 3 at pixel 1000 → whole frame in mode 0; o_eol every 640th pixel; o_frame_done pulses once; next frame inverted.
- Assert db_rstn low mid-line at x=300 → outputs clear asynchronously; the next accepted pixel carries o_sof=1.
